// File: rtl/pixel_filter_pkg.sv
// Shared encodings for the pixel filter: filter mode select and blur FSM state.
package pixel_filter_pkg;

    localparam int unsigned MODE_WIDTH  = 2;
    localparam int unsigned STATE_WIDTH = 2;

    // Filter select as presented on the mode port
    typedef enum logic [MODE_WIDTH-1:0] {
        MODE_BYPASS = 2'b00,
        MODE_INVERT = 2'b01,
        MODE_THRESH = 2'b10,
        MODE_BLUR   = 2'b11
    } mode_e;

    // Blur line sequencing: prime the window, stream, drain the last column
    typedef enum logic [STATE_WIDTH-1:0] {
        ST_FILL  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

endpackage

// File: rtl/pixel_filter_blur_tap3.sv
// blur_tap3: combinational 3-tap [1 2 1]/4 kernel with round-to-nearest.
//   left, center, right : neighbouring pixels p[c-1], p[c], p[c+1]
//   blur_c              : (left + 2*center + right + 2) >> 2
module blur_tap3 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] left,
    input  logic [DATA_WIDTH-1:0] center,
    input  logic [DATA_WIDTH-1:0] right,
    output logic [DATA_WIDTH-1:0] blur_c
);

    // Two extra bits hold 4 * max pixel + rounding without overflow
    localparam int unsigned SUM_WIDTH = DATA_WIDTH + 2;

    logic [SUM_WIDTH-1:0] sum;

    assign sum    = SUM_WIDTH'(left) + (SUM_WIDTH'(center) << 1) + SUM_WIDTH'(right)
                  + SUM_WIDTH'(2);
    assign blur_c = sum[SUM_WIDTH-1:2];

endmodule

// File: rtl/pixel_filter.sv
// pixel_filter: streams pixels from a first-word-fall-through FIFO through a
// per-line selectable filter (bypass / invert / threshold / 3-tap blur) into
// a valid/ready output register.
//   clk, rst_n               : clock, asynchronous active-low reset
//   fifo_empty, fifo_rd_data : upstream FWFT FIFO head
//   fifo_rd_en               : pop strobe (combinational, same-cycle with head)
//   mode, thresh             : filter select (latched at column 0), threshold
//   out_valid/ready/data     : output handshake and filtered pixel
//   out_sol, out_eol         : output pixel is column 0 / last column
//   line_done                : last-column output accepted this cycle
module pixel_filter
    import pixel_filter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LINE_WIDTH = 64,
    parameter int unsigned COL_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] thresh,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sol,
    output logic                  out_eol,
    output logic                  line_done
);

    localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(LINE_WIDTH - 1);
    localparam logic [COL_WIDTH-1:0] COL_ONE  = COL_WIDTH'(1);

    state_e                state;
    mode_e                 mode_q;
    mode_e                 mode_in;
    mode_e                 mode_eff;
    logic [COL_WIDTH-1:0]  col;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] pix_f;
    logic [DATA_WIDTH-1:0] tap_right;
    logic [DATA_WIDTH-1:0] blur_c;
    logic                  col0;
    logic                  last_col;
    logic                  can_load;
    logic                  blur_fill;
    logic                  pop;

    assign mode_in  = mode_e'(mode);
    assign col0     = (col == '0);
    assign last_col = (col == LAST_COL);
    // Column 0 uses the live mode because mode_q only captures it on that pop
    assign mode_eff = col0 ? mode_in : mode_q;
    assign can_load = !out_valid || out_ready;
    // Priming the blur window produces no output, so it may pop under backpressure
    assign blur_fill = (state == ST_FILL) && col0 && (mode_in == MODE_BLUR);
    assign pop       = rst_n && !fifo_empty && (state != ST_FLUSH) && (can_load || blur_fill);

    assign fifo_rd_en = pop;
    assign line_done  = out_valid && out_ready && out_eol;

    // Point filters for the non-blur modes
    always_comb begin
        pix_f = fifo_rd_data;
        case (mode_eff)
            MODE_INVERT: pix_f = ~fifo_rd_data;
            MODE_THRESH: pix_f = (fifo_rd_data >= thresh) ? {DATA_WIDTH{1'b1}} : '0;
            default:     pix_f = fifo_rd_data;
        endcase
    end

    // Right tap replicates the last pixel while draining the line
    assign tap_right = (state == ST_FLUSH) ? cur : fifo_rd_data;

    blur_tap3 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_blur_tap3 (
        .left   (prev),
        .center (cur),
        .right  (tap_right),
        .blur_c (blur_c)
    );

    // Line sequencing, blur window and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            mode_q    <= MODE_BYPASS;
            col       <= '0;
            prev      <= '0;
            cur       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            // An accepted output is retired unless a new one loads below
            if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (pop) begin
                col <= last_col ? '0 : col + COL_ONE;
                if (col0) begin
                    mode_q <= mode_in;
                end
            end

            case (state)
                ST_FILL: begin
                    if (pop) begin
                        if (blur_fill) begin
                            prev  <= fifo_rd_data;
                            cur   <= fifo_rd_data;
                            state <= ST_RUN;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= pix_f;
                            out_sol   <= col0;
                            out_eol   <= last_col;
                        end
                    end
                end
                ST_RUN: begin
                    // Popping column c completes output column c-1
                    if (pop) begin
                        out_valid <= 1'b1;
                        out_data  <= blur_c;
                        out_sol   <= (col == COL_ONE);
                        out_eol   <= 1'b0;
                        prev      <= cur;
                        cur       <= fifo_rd_data;
                        if (last_col) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (can_load) begin
                        out_valid <= 1'b1;
                        out_data  <= blur_c;
                        out_sol   <= 1'b0;
                        out_eol   <= 1'b1;
                        state     <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_filter.sv
// Scoreboard bench for pixel_filter with LINE_WIDTH=4, DATA_WIDTH=8.
module tb_pixel_filter;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 4;
    localparam int unsigned CW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sol;
        logic          eol;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic [1:0]    mode;
    logic [DW-1:0] thresh;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sol;
    logic          out_eol;
    logic          line_done;

    exp_t          exp_q[$];
    logic [DW-1:0] pix_q[$];
    int            checks;
    int            errors;
    int            pop_cnt;
    int            hold;
    bit            stall_next;
    bit            sb_en;
    bit            chk_rd_stall;

    pixel_filter #(
        .DATA_WIDTH (DW),
        .LINE_WIDTH (LW),
        .COL_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .mode         (mode),
        .thresh       (thresh),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sol      (out_sol),
        .out_eol      (out_eol),
        .line_done    (line_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT FIFO model and out_ready pattern
    initial begin
        bit popped;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        out_ready    = 1'b1;
        forever begin
            @(negedge clk);
            popped = fifo_rd_en;
            @(posedge clk);
            #1;
            if (popped && pix_q.size() > 0) begin
                void'(pix_q.pop_front());
                pop_cnt++;
            end
            if (stall_next && out_valid) begin
                hold       = 3;
                stall_next = 1'b0;
            end
            out_ready = (hold == 0);
            if (hold > 0) hold--;
            fifo_empty   = (pix_q.size() == 0);
            fifo_rd_data = (pix_q.size() == 0) ? '0 : pix_q[0];
        end
    end

    // Monitor: compare each accepted output, and held data while stalled
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        if (sb_en) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output: got data=%0h sol=%0b eol=%0b, expected none",
                                     out_data, out_sol, out_eol);
                        end
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (out_data !== e.data || out_sol !== e.sol || out_eol !== e.eol ||
                            line_done !== e.eol) begin
                            errors++;
                            $display("FAIL output: got data=%0h sol=%0b eol=%0b line_done=%0b, expected data=%0h sol=%0b eol=%0b line_done=%0b",
                                     out_data, out_sol, out_eol, line_done, e.data, e.sol, e.eol, e.eol);
                        end
                    end
                end else if (out_valid && !out_ready && exp_q.size() > 0) begin
                    checks++;
                    if (out_data !== exp_q[0].data || (chk_rd_stall && fifo_rd_en !== 1'b0)) begin
                        errors++;
                        $display("FAIL stall_hold: got data=%0h rd_en=%0b, expected data=%0h rd_en=0",
                                 out_data, fifo_rd_en, exp_q[0].data);
                    end
                end
            end
        end
    end

    task automatic push_pix(input logic [DW-1:0] a, b, c, d);
        pix_q.push_back(a);
        pix_q.push_back(b);
        pix_q.push_back(c);
        pix_q.push_back(d);
    endtask

    task automatic push_exp(input logic [DW-1:0] a, b, c, d);
        exp_q.push_back('{data: a, sol: 1'b1, eol: 1'b0});
        exp_q.push_back('{data: b, sol: 1'b0, eol: 1'b0});
        exp_q.push_back('{data: c, sol: 1'b0, eol: 1'b0});
        exp_q.push_back('{data: d, sol: 1'b0, eol: 1'b1});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || pix_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_drain: %0d outputs and %0d pixels left, expected 0 and 0",
                     name, exp_q.size(), pix_q.size());
            exp_q.delete();
            pix_q.delete();
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (pop_cnt < target && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL pop_wait: got %0d pops, expected %0d", pop_cnt, target);
        end
    endtask

    task automatic reset_check(input string name);
        @(negedge clk);
        checks++;
        if ({fifo_rd_en, out_valid, out_data, out_sol, out_eol, line_done} !== '0) begin
            errors++;
            $display("FAIL %s: got rd_en=%0b valid=%0b data=%0h sol=%0b eol=%0b line_done=%0b, expected all 0",
                     name, fifo_rd_en, out_valid, out_data, out_sol, out_eol, line_done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        checks       = 0;
        errors       = 0;
        pop_cnt      = 0;
        hold         = 0;
        stall_next   = 1'b0;
        chk_rd_stall = 1'b0;
        sb_en        = 1'b1;
        rst_n        = 1'b0;
        mode         = 2'b00;
        thresh       = '0;

        repeat (2) @(posedge clk);
        reset_check("reset_state");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Bypass
        mode = 2'b00;
        push_exp(8'd10, 8'd20, 8'd30, 8'd40);
        push_pix(8'd10, 8'd20, 8'd30, 8'd40);
        wait_drain("bypass");

        // Blur, two lines back to back: FLUSH must not consume the next line
        mode = 2'b11;
        push_exp(8'd1, 8'd4, 8'd8, 8'd11);
        push_exp(8'd100, 8'd125, 8'd175, 8'd200);
        push_pix(8'd0, 8'd4, 8'd8, 8'd12);
        push_pix(8'd100, 8'd100, 8'd200, 8'd200);
        wait_drain("blur");

        // Blur with the FIFO running dry mid-line
        push_exp(8'd20, 8'd32, 8'd48, 8'd60);
        pix_q.push_back(8'd16);
        pix_q.push_back(8'd32);
        repeat (6) @(posedge clk);
        #2;
        pix_q.push_back(8'd48);
        pix_q.push_back(8'd64);
        wait_drain("blur_gap");

        // Threshold
        mode   = 2'b10;
        thresh = 8'h80;
        push_exp(8'h00, 8'hFF, 8'hFF, 8'h00);
        push_pix(8'h7F, 8'h80, 8'hFF, 8'h00);
        wait_drain("thresh");

        // Invert with a 3-cycle stall after the first output
        mode         = 2'b01;
        chk_rd_stall = 1'b1;
        stall_next   = 1'b1;
        push_exp(8'hF5, 8'hEB, 8'hE1, 8'hD7);
        push_pix(8'h0A, 8'h14, 8'h1E, 8'h28);
        wait_drain("invert_stall");
        chk_rd_stall = 1'b0;

        // Mode change mid-line applies from the next line
        mode = 2'b00;
        push_exp(8'd1, 8'd2, 8'd3, 8'd4);
        push_exp(8'd250, 8'd249, 8'd248, 8'd247);
        base = pop_cnt;
        push_pix(8'd1, 8'd2, 8'd3, 8'd4);
        push_pix(8'd5, 8'd6, 8'd7, 8'd8);
        wait_pops(base + 2);
        mode = 2'b01;
        wait_drain("mode_change");

        // Reset during blur RUN discards the partial line
        mode  = 2'b11;
        sb_en = 1'b0;
        base  = pop_cnt;
        push_pix(8'd50, 8'd60, 8'd70, 8'd80);
        wait_pops(base + 2);
        rst_n = 1'b0;
        reset_check("reset_midline");
        exp_q.delete();
        pix_q.delete();
        reset_check("reset_midline_hold");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        sb_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        push_exp(8'd8, 8'd8, 8'd8, 8'd8);
        push_pix(8'd8, 8'd8, 8'd8, 8'd8);
        wait_drain("post_reset_blur");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_filter.md
PIXEL_FILTER -- requirements
Module: pixel_filter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 Parameter LINE_WIDTH, default 64: pixels per line, legal range 2 to 2**COL_WIDTH.
REQ-003 Parameter COL_WIDTH, default 6: column counter width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous reset, active low.
REQ-007 fifo_empty  in  1  upstream FIFO empty; when low, fifo_rd_data is valid in the same cycle (first-word-fall-through).
REQ-008 fifo_rd_data  in  DATA_WIDTH  pixel at the head of the upstream FIFO.
REQ-009 fifo_rd_en  out  1  pop strobe; each cycle it is high consumes exactly one pixel.
REQ-010 mode  in  2  filter select: 00 bypass, 01 invert, 10 threshold, 11 blur.
REQ-011 thresh  in  DATA_WIDTH  threshold level, used only in threshold mode.
REQ-012 out_valid  out  1  out_data, out_sol and out_eol are valid.
REQ-013 out_ready  in  1  downstream accepts the output when out_valid and out_ready are both high.
REQ-014 out_data  out  DATA_WIDTH  filtered pixel.
REQ-015 out_sol / out_eol  out  1 each  flag the output pixel at column 0 / column LINE_WIDTH-1.
REQ-016 line_done  out  1  one-cycle pulse on the cycle the column LINE_WIDTH-1 output is accepted.

Function
REQ-017 The output register SHALL load only when out_valid is low or out_ready is high; out_data and the flags SHALL hold stable while out_valid is high and out_ready is low.
REQ-018 fifo_rd_en SHALL be high exactly when fifo_empty is low, the output register can load (or, for blur column 0, no output is needed), and the state is not FLUSH.
REQ-019 mode SHALL be latched into mode_q when a column-0 pixel is consumed; a mode change mid-line SHALL take effect at the next line.
REQ-020 Bypass: out = pixel. Invert: out = ~pixel. Threshold: out = all-ones if pixel >= thresh, else 0. Latency for all three SHALL be 1 cycle from pop to out_valid.
REQ-021 Blur SHALL compute out[c] = (p[c-1] + 2*p[c] + p[c+1] + 2) >> 2 using a DATA_WIDTH+2-bit sum, with p[-1] = p[0] and p[LINE_WIDTH] = p[LINE_WIDTH-1] (edge replication within the line).
REQ-022 Blur FSM has three states.
- FILL: on popping column 0, set prev = cur = p0 with no output; go to RUN.
- RUN: each pop of column c emits out[c-1]; after popping column LINE_WIDTH-1, go to FLUSH.
- FLUSH: emit out[LINE_WIDTH-1] without popping; then go to FILL.
REQ-023 Every mode SHALL produce exactly LINE_WIDTH outputs per line, in column order, with no drop or duplication under any pattern of out_ready or fifo_empty.
REQ-024 The column counter SHALL wrap from LINE_WIDTH-1 to 0; out_sol and out_eol SHALL follow output column, not input column.
REQ-025 fifo_empty going high mid-line SHALL stall the block without corrupting the window; FLUSH SHALL proceed even when fifo_empty is high.

Reset
REQ-026 While rst_n is low, the following SHALL be 0: fifo_rd_en, out_valid, out_data, out_sol, out_eol, line_done, the column counter, prev, cur, and mode_q. State SHALL be FILL.
REQ-027 Reset asserted mid-line SHALL discard the partial line; the first pop after release SHALL be treated as column 0.

Structure
REQ-028 Package pixel_filter_pkg SHALL hold the mode encodings (MODE_BYPASS, MODE_INVERT, MODE_THRESH, MODE_BLUR) and the FSM state encoding.
REQ-029 The 3-tap kernel arithmetic SHALL be one sub-module, blur_tap3, purely combinational; the FSM, counters and handshake stay in pixel_filter.

Verification (LINE_WIDTH=4, DATA_WIDTH=8)
REQ-030 Bypass, line 10,20,30,40, out_ready=1 -> outputs 10,20,30,40; sol on 10, eol and line_done on 40.
REQ-031 Blur, line 0,4,8,12 -> outputs 1,4,8,11; output 11 appears in the FLUSH cycle with no pop.
REQ-032 Threshold, thresh=0x80, pixels 0x7F,0x80,0xFF,0x00 -> outputs 0x00,0xFF,0xFF,0x00.
REQ-033 Invert, out_ready low for 3 cycles after the first output 0xF5 (input 0x0A) -> out_data held at 0xF5, fifo_rd_en low, 4 outputs total per line.
REQ-034 mode changed from bypass to invert after column 1 -> current line stays bypass; next line is inverted starting at its sol.
REQ-035 Reset pulse during blur RUN at column 2, then line 8,8,8,8 -> all outputs 0 during reset; then 8,8,8,8 with correct sol/eol.
